z_sequencer: RTL and testbench
==============================

Name: z_sequencer

Overview:
- Control-side initiator for the z accumulation datapath.
- Drives the datapath's sel / enable_prev / enable_out strobes, the weight-BRAM read address and the activation index (k select) for one full layer.
- Per neuron, the datapath loads the bias, then accumulates N_IN weight*activation products; a z_valid pulse then tells the downstream activation stage that the datapath output holds that neuron's z.
- Sits between the layer controller (start/done) and one z datapath instance plus its weight BRAM.

Parameters:
- AWIDTH, 10, weight-BRAM address width.
- N_IN, 4, inputs (products) per neuron; minimum 1.
- N_NEURON, 16, neurons per layer; minimum 1.
- KWIDTH, clog2(N_IN) (minimum 1), width of k_idx.
- NWIDTH, clog2(N_NEURON) (minimum 1), width of neuron_idx.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a layer pass; sampled only in IDLE.
- base_addr  input  AWIDTH  BRAM address of neuron 0's bias; sampled with start.
- bram_addr  output  AWIDTH  registered weight-BRAM read address.
- k_idx  output  KWIDTH  activation index; valid in MAC cycles.
- sel  output  1  datapath mux: 1 = load BRAM word into prev register, 0 = load out.
- enable_prev  output  1  datapath prev-register enable.
- enable_out  output  1  datapath out-register enable.
- neuron_idx  output  NWIDTH  neuron currently being computed.
- z_valid  output  1  one-cycle pulse; the datapath out holds z[neuron_idx].
- busy  output  1  high from the cycle after start is accepted until DONE of the last neuron, inclusive.
- done  output  1  one-cycle pulse, coincident with the last z_valid.

Behaviour:
- Reset (asynchronous assert, low): every output is 0, the FSM goes to IDLE and both counters clear. Takes effect immediately mid-operation; no partial z_valid is issued.
- BRAM timing:
  - One-cycle read latency: the address driven in cycle c is returned on in_BRAM in cycle c+1.
  - bram_addr is a flop and holds when not updated.
- Neuron memory layout: bias at B(n) = base_addr + n*(N_IN+1); weight i at B(n)+1+i. Addition is modulo 2^AWIDTH, so the address wraps.
- FSM states: IDLE, LD_ADDR, BIAS, MAC, FWD, DONE.
  - IDLE: start=1 → bram_addr <= base_addr, neuron cnt=0, next state LD_ADDR.
  - LD_ADDR: bram_addr = B(n); schedule bram_addr <= B(n)+1; term cnt i=0 → BIAS.
  - BIAS: sel=1, enable_prev=1 (prev <= bias) → MAC.
  - MAC: enable_out=1, k_idx=i, in_BRAM = weight i (out <= w_i*x_i + prev).
    - If i < N_IN-1: bram_addr <= B(n)+2+i → FWD.
    - Else → DONE.
  - FWD: sel=0, enable_prev=1 (prev <= out); i <= i+1 → MAC.
  - DONE: z_valid=1.
    - If n < N_NEURON-1: n <= n+1, bram_addr <= B(n+1) → LD_ADDR.
    - Else: done=1 → IDLE.
- Strobes are never high outside the states listed; enable_out and enable_prev are never high in the same cycle.
- Latency: 2*N_IN+2 cycles per neuron, with the start cycle counting as cycle 0 (N_IN=4: z_valid in cycle 10). Layer total: N_NEURON*(2*N_IN+2) cycles.
- Start handling:
  - start while busy is ignored.
  - start high in the IDLE cycle following done begins a new pass.
  - base_addr is latched at acceptance; later changes have no effect on the pass.
- N_IN=1: no FWD state visited (BIAS → MAC → DONE).
- Strobes and bram_addr are registered (Moore) outputs.

Decomposition:
- Shared package:
  - FSM state encoding.
  - Layer-default constants (N_IN, N_NEURON, AWIDTH).
  - The clog2 width function.
- One natural sub-module: z_seq_counter (enable, synchronous clear, terminal-count flag), instantiated twice, once for the term count and once for the neuron count.

Test Plan:
- Reset: hold reset=0 with start=1 → all outputs 0, no state change. Release → still IDLE until start is sampled.
- Single neuron (N_NEURON=1, N_IN=4, base=0, BRAM {10,1,2,3,4}, activations by k_idx {2,3,4,5}), driving a real z datapath → z_valid and done in cycle 10, datapath out=50, bram_addr sequence 0,1,2,3,4.
- Default layer with base=0x100 → bias addresses 0x100, 0x105, …, 0x14B; 16 z_valid pulses spaced 10 cycles apart; done on the 16th; busy high for 160 cycles.
- Strobe check across the layer → enable_out&enable_prev never high together; sel=1 only in BIAS cycles.
- start pulsed mid-layer → ignored. start held high through done → new pass, LD_ADDR two cycles after done, neuron_idx=0.
- Reset asserted during the 3rd MAC of neuron 5 → outputs 0 immediately. Fresh start restarts at neuron 0.
- Address wrap with base=0x3FE → bias at 0x3FE, weights at 0x3FF, 0x000, 0x001, 0x002.

Source files
------------

// File: rtl/z_sequencer_pkg.sv
// Shared definitions for the z accumulation sequencer: FSM encoding,
// layer-default dimensions and the width helper used for index ports.
package z_sequencer_pkg;

  localparam int DEF_AWIDTH   = 10;
  localparam int DEF_N_IN     = 4;
  localparam int DEF_N_NEURON = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LD_ADDR = 3'd1,
    ST_BIAS    = 3'd2,
    ST_MAC     = 3'd3,
    ST_FWD     = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_e;

  // ceil(log2(value)), never below 1 so a count of 1 still yields a legal port
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    while ((32'sd1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/z_seq_counter.sv
// Up-counter with enable, synchronous clear (priority over enable) and a
// terminal-count flag raised while the count equals TERM.
module z_seq_counter #(
  parameter int WIDTH = 2,
  parameter int TERM  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERM);
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // count register: clear wins over enable, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (en) begin
      count_r <= count_r + ONE_VAL;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign tc    = (count_r == TERM_VAL);

endmodule

// File: rtl/z_sequencer.sv
// Layer sequencer for the z datapath: walks every neuron of a layer, issuing
// the weight-BRAM addresses and the sel / enable_prev / enable_out strobes so
// the datapath loads the bias then accumulates N_IN products per neuron.
// All outputs are flops; strobes are decoded from the next state.
module z_sequencer
  import z_sequencer_pkg::*;
#(
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int N_IN     = DEF_N_IN,
  parameter int N_NEURON = DEF_N_NEURON,
  parameter int KWIDTH   = clog2_min1(N_IN),
  parameter int NWIDTH   = clog2_min1(N_NEURON)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  output logic [AWIDTH-1:0] bram_addr,
  output logic [KWIDTH-1:0] k_idx,
  output logic              sel,
  output logic              enable_prev,
  output logic              enable_out,
  output logic [NWIDTH-1:0] neuron_idx,
  output logic              z_valid,
  output logic              busy,
  output logic              done
);

  // distance between consecutive neuron records: bias plus N_IN weights
  localparam logic [AWIDTH-1:0] STRIDE   = AWIDTH'(N_IN + 1);
  localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);

  seq_state_e        state_r;
  seq_state_e        state_nxt_s;
  logic [AWIDTH-1:0] bias_addr_r;
  logic [AWIDTH-1:0] bias_addr_nxt_s;
  logic [AWIDTH-1:0] bram_addr_r;
  logic [AWIDTH-1:0] bram_addr_nxt_s;
  logic              term_clr_s;
  logic              term_en_s;
  logic              term_tc_s;
  logic [KWIDTH-1:0] term_cnt_s;
  logic              nrn_clr_s;
  logic              nrn_en_s;
  logic              nrn_tc_s;
  logic [NWIDTH-1:0] nrn_cnt_s;
  logic              sel_r;
  logic              enable_prev_r;
  logic              enable_out_r;
  logic              z_valid_r;
  logic              busy_r;
  logic              done_r;

  z_seq_counter #(
    .WIDTH (KWIDTH),
    .TERM  (N_IN - 1)
  ) u_term_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (term_clr_s),
    .en    (term_en_s),
    .count (term_cnt_s),
    .tc    (term_tc_s)
  );

  z_seq_counter #(
    .WIDTH (NWIDTH),
    .TERM  (N_NEURON - 1)
  ) u_nrn_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (nrn_clr_s),
    .en    (nrn_en_s),
    .count (nrn_cnt_s),
    .tc    (nrn_tc_s)
  );

  // state, current bias address and BRAM address registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      bias_addr_r <= {AWIDTH{1'b0}};
      bram_addr_r <= {AWIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      bias_addr_r <= bias_addr_nxt_s;
      bram_addr_r <= bram_addr_nxt_s;
    end
  end

  // next-state, counter control and next BRAM address
  always_comb begin
    state_nxt_s     = state_r;
    bias_addr_nxt_s = bias_addr_r;
    bram_addr_nxt_s = bram_addr_r;
    term_clr_s      = 1'b0;
    term_en_s       = 1'b0;
    nrn_clr_s       = 1'b0;
    nrn_en_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          // base_addr is captured here; later changes do not affect the pass
          bias_addr_nxt_s = base_addr;
          bram_addr_nxt_s = base_addr;
          nrn_clr_s       = 1'b1;
          state_nxt_s     = ST_LD_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LD_ADDR: begin
        // bias is on the bus now; point at weight 0 for the first MAC
        bram_addr_nxt_s = bias_addr_r + ADDR_ONE;
        term_clr_s      = 1'b1;
        state_nxt_s     = ST_BIAS;
      end
      ST_BIAS: begin
        state_nxt_s = ST_MAC;
      end
      ST_MAC: begin
        if (!term_tc_s) begin
          bram_addr_nxt_s = bram_addr_r + ADDR_ONE;
          state_nxt_s     = ST_FWD;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_FWD: begin
        term_en_s   = 1'b1;
        state_nxt_s = ST_MAC;
      end
      ST_DONE: begin
        if (!nrn_tc_s) begin
          nrn_en_s        = 1'b1;
          bias_addr_nxt_s = bias_addr_r + STRIDE;
          bram_addr_nxt_s = bias_addr_r + STRIDE;
          state_nxt_s     = ST_LD_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Moore output flops decoded from the state about to be entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_r         <= 1'b0;
      enable_prev_r <= 1'b0;
      enable_out_r  <= 1'b0;
      z_valid_r     <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      sel_r         <= (state_nxt_s == ST_BIAS);
      enable_prev_r <= (state_nxt_s == ST_BIAS) || (state_nxt_s == ST_FWD);
      enable_out_r  <= (state_nxt_s == ST_MAC);
      z_valid_r     <= (state_nxt_s == ST_DONE);
      busy_r        <= (state_nxt_s != ST_IDLE);
      // neuron count is stable on entry to DONE, so tc marks the last neuron
      done_r        <= (state_nxt_s == ST_DONE) && nrn_tc_s;
    end
  end

  assign bram_addr   = bram_addr_r;
  assign k_idx       = term_cnt_s;
  assign neuron_idx  = nrn_cnt_s;
  assign sel         = sel_r;
  assign enable_prev = enable_prev_r;
  assign enable_out  = enable_out_r;
  assign z_valid     = z_valid_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_z_sequencer.sv
// Directed bench for z_sequencer: a default 16x4 layer instance plus a
// single-neuron instance driving a small behavioural z datapath.
module tb_z_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start1;
  logic [9:0]  base_addr;
  logic [9:0]  base_addr1;

  logic [9:0]  bram_addr;
  logic [1:0]  k_idx;
  logic        sel, enable_prev, enable_out, z_valid, busy, done;
  logic [3:0]  neuron_idx;

  logic [9:0]  bram_addr1;
  logic [1:0]  k_idx1;
  logic        sel1, ep1, eo1, z_valid1, busy1, done1;
  logic [0:0]  neuron_idx1;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem1 [0:7];
  logic [15:0] act  [0:3];
  logic [15:0] in_bram = 16'd0;
  logic [15:0] prev_r  = 16'd0;
  logic [15:0] out_r   = 16'd0;

  always #5 clk = ~clk;

  z_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .bram_addr(bram_addr), .k_idx(k_idx), .sel(sel), .enable_prev(enable_prev),
    .enable_out(enable_out), .neuron_idx(neuron_idx), .z_valid(z_valid),
    .busy(busy), .done(done)
  );

  z_sequencer #(.N_NEURON(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .base_addr(base_addr1),
    .bram_addr(bram_addr1), .k_idx(k_idx1), .sel(sel1), .enable_prev(ep1),
    .enable_out(eo1), .neuron_idx(neuron_idx1), .z_valid(z_valid1),
    .busy(busy1), .done(done1)
  );

  // behavioural BRAM (1-cycle latency) and z datapath for the single-neuron instance
  always @(posedge clk) begin
    in_bram <= (bram_addr1 < 10'd8) ? mem1[bram_addr1[2:0]] : 16'd0;
    if (ep1) prev_r <= sel1 ? in_bram : out_r;
    if (eo1) out_r <= in_bram * act[k_idx1] + prev_r;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; start1 = 1'b1;
    base_addr = 10'h123; base_addr1 = 10'h005;
    repeat (3) tick();
    checks++;
    if ({bram_addr, k_idx, neuron_idx} !== 16'd0) begin
      errors++;
      $display("FAIL reset_idx got %h exp 0", {bram_addr, k_idx, neuron_idx});
    end
    checks++;
    if ({sel, enable_prev, enable_out, z_valid, busy, done} !== 6'd0) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 000000", {sel, enable_prev, enable_out, z_valid, busy, done});
    end
    start = 1'b0; start1 = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, busy1, bram_addr} !== 12'd0) begin
      errors++;
      $display("FAIL reset_release got %h exp 0", {busy, busy1, bram_addr});
    end
  endtask

  task automatic test_single_neuron();
    logic [9:0] exp_addr [1:10];
    exp_addr = '{10'd0, 10'd1, 10'd1, 10'd2, 10'd2, 10'd3, 10'd3, 10'd4, 10'd4, 10'd4};
    base_addr1 = 10'd0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if (bram_addr1 !== exp_addr[c]) begin
        errors++;
        $display("FAIL single_addr c=%0d got %0d exp %0d", c, bram_addr1, exp_addr[c]);
      end
      checks++;
      if ({z_valid1, done1, busy1, neuron_idx1} !== {(c == 10), (c == 10), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL single_flags c=%0d got %b exp %b", c, {z_valid1, done1, busy1, neuron_idx1},
                 {(c == 10), (c == 10), 1'b1, 1'b0});
      end
      if (c == 10) begin
        checks++;
        if (out_r !== 16'd50) begin
          errors++;
          $display("FAIL single_z got %0d exp 50", out_r);
        end
      end
      if (c < 10) tick();
    end
    tick();
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got %b exp 0", busy1);
    end
  endtask

  task automatic test_layer();
    int busy_cnt = 0;
    int zv_cnt = 0;
    int ph;
    int n;
    logic [4:0] exp_str;
    logic [9:0] exp_a;
    base_addr = 10'h100; start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = 10'h200;               // changes after acceptance must not matter
    for (int c = 1; c <= 160; c++) begin
      ph = c % 10;
      n  = (c - 1) / 10;
      if (c == 50) start = 1'b1;       // mid-layer start, must be ignored
      if (c == 51) start = 1'b0;
      if (c == 159) start = 1'b1;      // held through done
      exp_str = {(ph == 2), (ph == 2 || ph == 4 || ph == 6 || ph == 8),
                 (ph == 3 || ph == 5 || ph == 7 || ph == 9), (ph == 0), (c == 160)};
      checks++;
      if ({sel, enable_prev, enable_out, z_valid, done} !== exp_str) begin
        errors++;
        $display("FAIL layer_strobes c=%0d got %b exp %b", c, {sel, enable_prev, enable_out, z_valid, done}, exp_str);
      end
      checks++;
      if ((enable_prev & enable_out) !== 1'b0) begin
        errors++;
        $display("FAIL layer_overlap c=%0d got 1 exp 0", c);
      end
      checks++;
      if (neuron_idx !== 4'(n)) begin
        errors++;
        $display("FAIL layer_nidx c=%0d got %0d exp %0d", c, neuron_idx, n);
      end
      if (ph == 1) begin
        exp_a = 10'h100 + 10'(5 * n);
        checks++;
        if (bram_addr !== exp_a) begin
          errors++;
          $display("FAIL layer_bias_addr c=%0d got %h exp %h", c, bram_addr, exp_a);
        end
      end
      if (ph == 3 || ph == 5 || ph == 7 || ph == 9) begin
        checks++;
        if (k_idx !== 2'((ph - 3) / 2)) begin
          errors++;
          $display("FAIL layer_k c=%0d got %0d exp %0d", c, k_idx, (ph - 3) / 2);
        end
      end
      if (busy === 1'b1) busy_cnt++;
      if (z_valid === 1'b1) zv_cnt++;
      if (c < 160) tick();
    end
    checks++;
    if (busy_cnt != 160) begin
      errors++;
      $display("FAIL layer_busy_cycles got %0d exp 160", busy_cnt);
    end
    checks++;
    if (zv_cnt != 16) begin
      errors++;
      $display("FAIL layer_zvalid_count got %0d exp 16", zv_cnt);
    end
  endtask

  task automatic test_back_to_back();
    tick();                            // IDLE cycle after done, start still high
    checks++;
    if ({busy, z_valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_idle got %b exp 000", {busy, z_valid, done});
    end
    tick();                            // LD_ADDR of the new pass
    start = 1'b0;
    checks++;
    if ({busy, bram_addr, neuron_idx} !== {1'b1, 10'h200, 4'd0}) begin
      errors++;
      $display("FAIL b2b_restart got %h exp %h", {busy, bram_addr, neuron_idx}, {1'b1, 10'h200, 4'd0});
    end
  endtask

  task automatic test_reset_mid();
    repeat (56) tick();                // pass-relative cycle 57: third MAC of neuron 5
    checks++;
    if ({enable_out, neuron_idx, k_idx} !== {1'b1, 4'd5, 2'd2}) begin
      errors++;
      $display("FAIL mid_position got %h exp %h", {enable_out, neuron_idx, k_idx}, {1'b1, 4'd5, 2'd2});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({sel, enable_prev, enable_out, z_valid, busy, done, bram_addr, k_idx, neuron_idx} !== 22'd0) begin
      errors++;
      $display("FAIL mid_reset got %h exp 0",
               {sel, enable_prev, enable_out, z_valid, busy, done, bram_addr, k_idx, neuron_idx});
    end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    base_addr = 10'h010; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, bram_addr, neuron_idx} !== {1'b1, 10'h010, 4'd0}) begin
      errors++;
      $display("FAIL mid_restart got %h exp %h", {busy, bram_addr, neuron_idx}, {1'b1, 10'h010, 4'd0});
    end
    repeat (9) tick();
    checks++;
    if ({z_valid, done, neuron_idx} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL mid_first_z got %b exp 100000", {z_valid, done, neuron_idx});
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    logic [9:0] exp_a;
    base_addr = 10'h3FE; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      case (c)
        1:       exp_a = 10'h3FE;
        2:       exp_a = 10'h3FF;
        4:       exp_a = 10'h000;
        6:       exp_a = 10'h001;
        8:       exp_a = 10'h002;
        11:      exp_a = 10'h003;
        default: exp_a = bram_addr;
      endcase
      if (c == 1 || c == 2 || c == 4 || c == 6 || c == 8 || c == 11) begin
        checks++;
        if (bram_addr !== exp_a) begin
          errors++;
          $display("FAIL wrap_addr c=%0d got %h exp %h", c, bram_addr, exp_a);
        end
      end
      if (c < 11) tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    mem1[0] = 16'd10; mem1[1] = 16'd1; mem1[2] = 16'd2; mem1[3] = 16'd3;
    mem1[4] = 16'd4;  mem1[5] = 16'd0; mem1[6] = 16'd0; mem1[7] = 16'd0;
    act[0] = 16'd2; act[1] = 16'd3; act[2] = 16'd4; act[3] = 16'd5;
    test_reset();
    test_single_neuron();
    test_layer();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
